// File: rtl/req_arbiter.sv
// req_arbiter: round-robin front end of the request/acknowledge handshake.
// Client requests are held in sticky pending bits and served one at a time.
// For each served client, the block issues a one-cycle req downstream, waits
// for ack, and then pulses cli_done for that client.
// Optional feature: define REQ_ARB_TIMEOUT_EN to add a TIMEOUT_W-bit watchdog
// that aborts a stalled transaction and pulses cli_err instead of cli_done.
module req_arbiter #(
    parameter int NCLIENTS  = 4,
    parameter int IDW       = 2,
    parameter int TIMEOUT_W = 12
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NCLIENTS-1:0] cli_req,
    output logic [NCLIENTS-1:0] cli_done,
    output logic [NCLIENTS-1:0] cli_err,
    output logic                req,
    input  logic                ack,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NCLIENTS - 1);

    state_t              state;
    logic [NCLIENTS-1:0] pending;
    logic [IDW-1:0]      rr_ptr;

    logic                pick_found;
    logic [IDW-1:0]      pick_id;
    logic [IDW-1:0]      scan_id;
    logic [NCLIENTS-1:0] grant_mask;
    logic [NCLIENTS-1:0] clr_mask;
    logic [IDW-1:0]      rr_next;

`ifdef REQ_ARB_TIMEOUT_EN
    // Last count value before the watchdog would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));
    logic [TIMEOUT_W-1:0] wd_cnt;
`endif

    // Round-robin pick: first pending client at or after rr_ptr, wrapping.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            scan_id = IDW'((int'(rr_ptr) + k) % NCLIENTS);
            if (!pick_found && pending[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // One-hot view of the served client, and its clear strobe on completion.
    always_comb begin
        grant_mask = NCLIENTS'(1) << grant_id;
        clr_mask   = ((state == DONE) || (state == ABORT)) ? grant_mask : '0;
        rr_next    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end

    // Sticky pending bits; a new request in the clear cycle wins and re-queues.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | cli_req;
        end
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            cli_done <= '0;
`ifdef REQ_ARB_TIMEOUT_EN
            cli_err  <= '0;
            wd_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= REQ;
                        grant_id <= pick_id;
                        req      <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    req   <= 1'b0;
`ifdef REQ_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (ack) begin
                        state    <= DONE;
                        cli_done <= grant_mask;
`ifdef REQ_ARB_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        state   <= ABORT;
                        cli_err <= grant_mask;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cli_done <= '0;
                    busy     <= 1'b0;
                    rr_ptr   <= rr_next;
                end
                ABORT: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= rr_next;
`ifdef REQ_ARB_TIMEOUT_EN
                    cli_err <= '0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef REQ_ARB_TIMEOUT_EN
    // Without the watchdog no transaction can be aborted.
    assign cli_err = '0;
`endif

endmodule

// File: tb/tb_req_arbiter.sv
// Directed self-checking bench for req_arbiter (NCLIENTS=4, IDW=2).
// The watchdog scenario runs only when REQ_ARB_TIMEOUT_EN is defined.
// In that build the bench uses TIMEOUT_W=4.
module tb_req_arbiter;

    localparam int NCLIENTS = 4;
    localparam int IDW      = 2;
`ifdef REQ_ARB_TIMEOUT_EN
    localparam int TIMEOUT_W = 4;
    localparam int ACK_DELAY = 10;
`else
    localparam int TIMEOUT_W = 12;
    localparam int ACK_DELAY = 1030;
`endif

    logic                clock   = 1'b0;
    logic                reset_n = 1'b0;
    logic [NCLIENTS-1:0] cli_req = '0;
    logic                ack     = 1'b0;
    logic [NCLIENTS-1:0] cli_done;
    logic [NCLIENTS-1:0] cli_err;
    logic                req;
    logic                busy;
    logic [IDW-1:0]      grant_id;

    req_arbiter #(
        .NCLIENTS (NCLIENTS),
        .IDW      (IDW),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cli_req (cli_req),
        .cli_done(cli_done),
        .cli_err (cli_err),
        .req     (req),
        .ack     (ack),
        .busy    (busy),
        .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int req_count = 0;
    int done_count[NCLIENTS] = '{default: 0};
    int err_count[NCLIENTS]  = '{default: 0};
    int bad_pulse = 0;
    logic [NCLIENTS-1:0] prev_de = '0;

    // Event counters sampled on the falling edge, away from DUT updates.
    always @(negedge clock) begin
        if (req === 1'b1) req_count++;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (cli_done[i] === 1'b1) done_count[i]++;
            if (cli_err[i] === 1'b1) err_count[i]++;
        end
        if ($countones(cli_done | cli_err) > 1 || ((cli_done | cli_err) & prev_de) != '0)
            bad_pulse++;
        prev_de = cli_done | cli_err;
    end

    task automatic do_reset();
        @(negedge clock);
        cli_req = '0;
        ack     = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Advance falling edges until req is seen, within a cycle budget.
    task automatic wait_req(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit f;
        int rc;
        int dc;
        @(negedge clock);
        checks++;
        if ({req, busy, grant_id, cli_done, cli_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", {req, busy, grant_id, cli_done, cli_err});
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (req_count !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: req_count=%0d busy=%b expected 0 0", req_count, busy);
        end
        // Reset while waiting for ack.
        cli_req = 4'b0001;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        repeat (3) @(negedge clock);
        checks++;
        if (!f || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_wait: found=%0d busy=%b expected 1 1", f, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req, busy, grant_id, cli_done, cli_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_wait: got %0h expected 0", {req, busy, grant_id, cli_done, cli_err});
        end
        @(negedge clock);
        reset_n = 1'b1;
        rc = req_count;
        dc = done_count[0] + err_count[0];
        repeat (10) @(negedge clock);
        checks++;
        if (req_count !== rc || done_count[0] + err_count[0] !== dc || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait_drop: req_delta=%0d done_delta=%0d busy=%b expected 0 0 0",
                     req_count - rc, done_count[0] + err_count[0] - dc, busy);
        end
        // Reset in the req cycle.
        cli_req = 4'b0100;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        reset_n = 1'b0;
        #1;
        checks++;
        if (!f || {req, busy, grant_id, cli_done, cli_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_req: found=%0d got %0h expected 1 0", f,
                     {req, busy, grant_id, cli_done, cli_err});
        end
        @(negedge clock);
        reset_n = 1'b1;
        rc = req_count;
        repeat (8) @(negedge clock);
        checks++;
        if (req_count !== rc) begin
            failures++;
            $display("FAIL reset_mid_req_drop: req_delta=%0d expected 0", req_count - rc);
        end
    endtask

    task automatic test_single();
        bit f;
        int rc;
        int dc;
        do_reset();
        rc = req_count;
        dc = done_count[1];
        @(negedge clock);
        cli_req = 4'b0010;
        @(negedge clock);
        cli_req = '0;
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: req=%b expected 0 one cycle after cli_req", req);
        end
        wait_req(1, f);
        checks++;
        if (!f || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL single_grant: found=%0d grant_id=%0d expected 1 1", f, grant_id);
        end
        repeat (ACK_DELAY) @(negedge clock);
        checks++;
        if (req_count - rc !== 1 || busy !== 1'b1 || done_count[1] !== dc) begin
            failures++;
            $display("FAIL single_wait: reqs=%0d busy=%b done=%0d expected 1 1 0",
                     req_count - rc, busy, done_count[1] - dc);
        end
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (cli_done !== 4'b0010 || cli_err !== 4'b0000) begin
            failures++;
            $display("FAIL single_done: cli_done=%b cli_err=%b expected 0010 0000", cli_done, cli_err);
        end
        @(negedge clock);
        checks++;
        if (cli_done !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after: cli_done=%b busy=%b expected 0000 0", cli_done, busy);
        end
    endtask

    task automatic test_round_robin();
        bit f;
        logic [3:0] exp_done;
        do_reset();
        @(negedge clock);
        cli_req = 4'b1111;
        @(negedge clock);
        cli_req = '0;
        for (int n = 0; n < 5; n++) begin
            if (n == 4) begin
                cli_req = 4'b0001;
                @(negedge clock);
                cli_req = '0;
            end
            exp_done = 4'b0001 << (n % 4);
            wait_req(6, f);
            checks++;
            if (!f || grant_id !== IDW'(n % 4)) begin
                failures++;
                $display("FAIL rr_grant_%0d: found=%0d grant_id=%0d expected 1 %0d", n, f, grant_id, n % 4);
            end
            @(negedge clock);
            ack = 1'b1;
            @(negedge clock);
            ack = 1'b0;
            checks++;
            if (cli_done !== exp_done) begin
                failures++;
                $display("FAIL rr_done_%0d: cli_done=%b expected %b", n, cli_done, exp_done);
            end
        end
    endtask

    task automatic test_merge_requeue();
        bit f;
        int rc;
        int dc;
        do_reset();
        rc = req_count;
        dc = done_count[2];
        @(negedge clock);
        cli_req = 4'b0100;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        @(negedge clock);
        cli_req = 4'b0100;
        @(negedge clock);
        cli_req = '0;
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (!f || cli_done !== 4'b0100) begin
            failures++;
            $display("FAIL merge_first_done: found=%0d cli_done=%b expected 1 0100", f, cli_done);
        end
        cli_req = 4'b0100;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        checks++;
        if (!f || grant_id !== 2'd2) begin
            failures++;
            $display("FAIL requeue_grant: found=%0d grant_id=%0d expected 1 2", f, grant_id);
        end
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        repeat (20) @(negedge clock);
        checks++;
        if (req_count - rc !== 2 || done_count[2] - dc !== 2) begin
            failures++;
            $display("FAIL merge_count: reqs=%0d dones=%0d expected 2 2", req_count - rc, done_count[2] - dc);
        end
    endtask

    task automatic test_spurious_ack();
        bit f;
        int rc;
        int dc;
        do_reset();
        rc = req_count;
        dc = done_count[3];
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || req_count !== rc || cli_done !== 4'b0000) begin
            failures++;
            $display("FAIL ack_idle: busy=%b reqs=%0d cli_done=%b expected 0 0 0000",
                     busy, req_count - rc, cli_done);
        end
        cli_req = 4'b1000;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (!f || busy !== 1'b1 || done_count[3] !== dc) begin
            failures++;
            $display("FAIL ack_req: found=%0d busy=%b dones=%0d expected 1 1 0", f, busy, done_count[3] - dc);
        end
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (cli_done !== 4'b1000) begin
            failures++;
            $display("FAIL ack_real_done: cli_done=%b expected 1000", cli_done);
        end
    endtask

`ifdef REQ_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit f;
        int e0;
        int d0;
        int e1;
        do_reset();
        e0 = err_count[0];
        d0 = done_count[0];
        e1 = err_count[1];
        @(negedge clock);
        cli_req = 4'b0011;
        @(negedge clock);
        cli_req = '0;
        wait_req(5, f);
        repeat (15) @(negedge clock);
        checks++;
        if (!f || cli_err !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_w15: found=%0d cli_err=%b busy=%b expected 1 0000 1", f, cli_err, busy);
        end
        @(negedge clock);
        checks++;
        if (cli_err !== 4'b0001 || cli_done !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_abort: cli_err=%b cli_done=%b expected 0001 0000", cli_err, cli_done);
        end
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (req !== 1'b1 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL timeout_next: req=%b grant_id=%0d expected 1 1", req, grant_id);
        end
        repeat (15) @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (cli_done !== 4'b0010 || cli_err !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_ack_wins: cli_done=%b cli_err=%b expected 0010 0000", cli_done, cli_err);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (err_count[0] - e0 !== 1 || done_count[0] - d0 !== 0 || err_count[1] - e1 !== 0) begin
            failures++;
            $display("FAIL timeout_counts: err0=%0d done0=%0d err1=%0d expected 1 0 0",
                     err_count[0] - e0, done_count[0] - d0, err_count[1] - e1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_merge_requeue();
        test_spurious_ack();
`ifdef REQ_ARB_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (bad_pulse !== 0) begin
            failures++;
            $display("FAIL done_err_pulse_shape: violations=%0d expected 0", bad_pulse);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
